// File: rtl/multi_word_instruction_decoder_if.sv
// ---------------------------------------------------------------------------
// multi_word_instruction_decoder_if
// Bundles the instruction-fetch handshake, the flush strobe and the decoded
// control bundle of multi_word_instruction_decoder into a single interface.
//
// Signals:
//   flush          - synchronous abort of any in-flight decode
//   instr_valid    - producer offers a 16-bit program word
//   instruction    - the offered program word
//   instr_ready    - decoder accepts the word on this edge
//   ctrl_valid     - control bundle is valid
//   ctrl_ready     - consumer takes the bundle on this edge
//   gpr_*          - GPR select / enables of the bundle
//   data_out(_en)  - immediate value and its bus-drive enable
//   mem_*          - data-memory address and strobes
//   illegal        - bundle carries an unsupported opcode
//
// Modports:
//   slave  - the decoder side
//   master - the producer/consumer side (testbench or surrounding core)
// ---------------------------------------------------------------------------
interface multi_word_instruction_decoder_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int MEM_ADDR_WIDTH = 16
);
  logic                      flush;
  logic                      instr_valid;
  logic [15:0]               instruction;
  logic                      instr_ready;
  logic                      ctrl_valid;
  logic                      ctrl_ready;
  logic [GPR_ADDR_WIDTH-1:0] gpr_write_addr;
  logic [GPR_ADDR_WIDTH-1:0] gpr_read_addr;
  logic                      gpr_write_en;
  logic                      gpr_read_en;
  logic [DATA_WIDTH-1:0]     data_out;
  logic                      data_out_en;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic                      mem_read_en;
  logic                      mem_write_en;
  logic                      illegal;

  modport slave (
    input  flush, instr_valid, instruction, ctrl_ready,
    output instr_ready, ctrl_valid, gpr_write_addr, gpr_read_addr,
           gpr_write_en, gpr_read_en, data_out, data_out_en,
           mem_addr, mem_read_en, mem_write_en, illegal
  );

  modport master (
    output flush, instr_valid, instruction, ctrl_ready,
    input  instr_ready, ctrl_valid, gpr_write_addr, gpr_read_addr,
           gpr_write_en, gpr_read_en, data_out, data_out_en,
           mem_addr, mem_read_en, mem_write_en, illegal
  );
endinterface

// File: rtl/multi_word_instruction_decoder.sv
// ---------------------------------------------------------------------------
// multi_word_instruction_decoder
// Decodes a stream of 16-bit program words into a registered control bundle.
// Single-word opcodes (LDI, MOV, NOP, illegal) produce a bundle one edge after
// acceptance. LDS/STS take a second word carrying a 16-bit data address and
// produce their bundle one edge after that second word is accepted.
//
// Ports:
//   clk   - sole clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - multi_word_instruction_decoder_if.slave (handshakes + bundle)
//
// Configuration:
//   DECODER_TWO_WORD_EN - when defined, LDS/STS are decoded as two-word
//                         instructions; otherwise they decode as illegal and
//                         the second-word state is never entered.
// ---------------------------------------------------------------------------
module multi_word_instruction_decoder #(
  parameter int DATA_WIDTH     = 8,
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int MEM_ADDR_WIDTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  multi_word_instruction_decoder_if.slave bus
);

  typedef enum logic {WORD1, WORD2} state_t;

  typedef struct packed {
    logic [GPR_ADDR_WIDTH-1:0] gpr_write_addr;
    logic [GPR_ADDR_WIDTH-1:0] gpr_read_addr;
    logic                      gpr_write_en;
    logic                      gpr_read_en;
    logic [DATA_WIDTH-1:0]     data_out;
    logic                      data_out_en;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic                      mem_read_en;
    logic                      mem_write_en;
    logic                      illegal;
  } bundle_t;

  state_t      state, state_n;
  logic        ctrl_valid_q, ctrl_valid_n;
  logic        pend_store_q, pend_store_n;
  logic [4:0]  pend_reg_q, pend_reg_n;
  bundle_t     bundle_q, bundle_n, dec;
  logic        load;
  logic        instr_ready;
  logic        accept;
  logic [15:0] instr;

  assign instr       = bus.instruction;
  // A new word can enter whenever the output register is empty or being
  // drained on this same edge; reset blocks acceptance outright.
  assign instr_ready = rst_n && (!ctrl_valid_q || bus.ctrl_ready);
  assign accept      = bus.instr_valid && instr_ready;

  // State, pending-first-word and bundle registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= WORD1;
      ctrl_valid_q <= 1'b0;
      pend_store_q <= 1'b0;
      pend_reg_q   <= '0;
      bundle_q     <= '0;
    end else begin
      state        <= state_n;
      ctrl_valid_q <= ctrl_valid_n;
      pend_store_q <= pend_store_n;
      pend_reg_q   <= pend_reg_n;
      bundle_q     <= bundle_n;
    end
  end

  // Next-state and bundle decode. The decoded bundle starts from all-zero so
  // every field an opcode does not use is forced to 0.
  always_comb begin
    state_n      = state;
    ctrl_valid_n = ctrl_valid_q;
    pend_store_n = pend_store_q;
    pend_reg_n   = pend_reg_q;
    bundle_n     = bundle_q;
    dec          = '0;
    load         = 1'b0;

    if (ctrl_valid_q && bus.ctrl_ready) begin
      ctrl_valid_n = 1'b0;
    end

    if (bus.flush) begin
      ctrl_valid_n = 1'b0;
      state_n      = WORD1;
      pend_store_n = 1'b0;
      pend_reg_n   = '0;
    end else if (accept) begin
      case (state)
        WORD1: begin
          load = 1'b1;
          if (instr[15:12] == 4'b1110) begin
            // LDI: destination restricted to the upper register half.
            dec.gpr_write_addr = GPR_ADDR_WIDTH'({1'b1, instr[7:4]});
            dec.data_out       = DATA_WIDTH'({instr[11:8], instr[3:0]});
            dec.data_out_en    = 1'b1;
            dec.gpr_write_en   = 1'b1;
          end else if (instr[15:10] == 6'b001011) begin
            // MOV: source MSB sits apart from its low nibble.
            dec.gpr_write_addr = GPR_ADDR_WIDTH'(instr[8:4]);
            dec.gpr_read_addr  = GPR_ADDR_WIDTH'({instr[9], instr[3:0]});
            dec.gpr_read_en    = 1'b1;
            dec.gpr_write_en   = 1'b1;
          end else if (instr == 16'h0000) begin
            dec = '0;
`ifdef DECODER_TWO_WORD_EN
          end else if (instr[15:10] == 6'b100100 && instr[3:0] == 4'b0000) begin
            // LDS (bit 9 = 0) / STS (bit 9 = 1): hold the register number and
            // wait for the address word; no bundle yet.
            load         = 1'b0;
            state_n      = WORD2;
            pend_store_n = instr[9];
            pend_reg_n   = instr[8:4];
`endif
          end else begin
            dec.illegal = 1'b1;
          end
        end
        WORD2: begin
          load         = 1'b1;
          dec.mem_addr = MEM_ADDR_WIDTH'(instr);
          if (pend_store_q) begin
            dec.gpr_read_addr = GPR_ADDR_WIDTH'(pend_reg_q);
            dec.mem_write_en  = 1'b1;
            dec.gpr_read_en   = 1'b1;
          end else begin
            dec.gpr_write_addr = GPR_ADDR_WIDTH'(pend_reg_q);
            dec.mem_read_en    = 1'b1;
            dec.gpr_write_en   = 1'b1;
          end
          state_n      = WORD1;
          pend_store_n = 1'b0;
          pend_reg_n   = '0;
        end
        default: state_n = WORD1;
      endcase

      if (load) begin
        bundle_n     = dec;
        ctrl_valid_n = 1'b1;
      end
    end
  end

  assign bus.instr_ready    = instr_ready;
  assign bus.ctrl_valid     = ctrl_valid_q;
  assign bus.gpr_write_addr = bundle_q.gpr_write_addr;
  assign bus.gpr_read_addr  = bundle_q.gpr_read_addr;
  assign bus.gpr_write_en   = bundle_q.gpr_write_en;
  assign bus.gpr_read_en    = bundle_q.gpr_read_en;
  assign bus.data_out       = bundle_q.data_out;
  assign bus.data_out_en    = bundle_q.data_out_en;
  assign bus.mem_addr       = bundle_q.mem_addr;
  assign bus.mem_read_en    = bundle_q.mem_read_en;
  assign bus.mem_write_en   = bundle_q.mem_write_en;
  assign bus.illegal        = bundle_q.illegal;

endmodule

// File: doc/multi_word_instruction_decoder.md
MULTI_WORD_INSTRUCTION_DECODER -- requirements
Module: multi_word_instruction_decoder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of the immediate data output.
REQ-002 SHALL have parameter GPR_ADDR_WIDTH, default 5, width of the GPR select outputs.
REQ-003 SHALL have parameter MEM_ADDR_WIDTH, default 16, width of the data-memory address output.
REQ-004 SHALL have port clk, input, 1, sole clock; all state changes on the rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port flush, input, 1, synchronous abort of all in-flight decode.
REQ-007 SHALL have port instr_valid, input, 1, instruction word offered.
REQ-008 SHALL have port instruction, input, 16, program word.
REQ-009 SHALL have port instr_ready, output, 1, word accepted on an edge where instr_valid && instr_ready.
REQ-010 SHALL have port ctrl_valid, output, 1, control bundle valid.
REQ-011 SHALL have port ctrl_ready, input, 1, consumer takes the bundle on an edge where ctrl_valid && ctrl_ready.
REQ-012 SHALL have port gpr_write_addr / gpr_read_addr, output, GPR_ADDR_WIDTH each, destination / source GPR.
REQ-013 SHALL have port gpr_write_en, output, 1, load GPR from data bus; gpr_read_en, output, 1, drive GPR onto data bus.
REQ-014 SHALL have port data_out, output, DATA_WIDTH, immediate; data_out_en, output, 1, data_out drives the bus (top level tristates).
REQ-015 SHALL have port mem_addr, output, MEM_ADDR_WIDTH; mem_read_en, mem_write_en, output, 1 each.
REQ-016 SHALL have port illegal, output, 1, unsupported opcode in current bundle.

Function
REQ-017 SHALL drive instr_ready = rst_n && (!ctrl_valid || ctrl_ready), giving one word per cycle throughput.
REQ-018 SHALL implement FSM WORD1 (await opcode) and WORD2 (await 16-bit address word); bundle held in an output register.
REQ-019 SHALL, on acceptance of a single-word opcode in WORD1, load the bundle and assert ctrl_valid on that edge (latency 1 edge).
REQ-020 SHALL decode LDI (1110 KKKK dddd KKKK): gpr_write_addr={1,d[7:4]}, data_out={i[11:8],i[3:0]}, data_out_en=1, gpr_write_en=1.
REQ-021 SHALL decode MOV (001011 r ddddd rrrr): gpr_write_addr=i[8:4], gpr_read_addr={i[9],i[3:0]}, gpr_read_en=1, gpr_write_en=1.
REQ-022 SHALL decode NOP (0x0000) as a valid bundle with all enables 0.
REQ-023 SHALL decode LDS (1001000 ddddd 0000): latch d, enter WORD2; no bundle until second word accepted.
REQ-024 SHALL decode STS (1001001 rrrrr 0000): latch r, enter WORD2.
REQ-025 SHALL, in WORD2, accept any 16-bit value as address; bundle: mem_addr=word, LDS -> gpr_write_addr=d, mem_read_en, gpr_write_en; STS -> gpr_read_addr=r, mem_write_en, gpr_read_en; return to WORD1.
REQ-026 SHALL emit any other opcode as a bundle with illegal=1, all enables 0, addresses 0.
REQ-027 SHALL force every unused field of a bundle to 0 (data_out=0 when data_out_en=0).
REQ-028 SHALL hold the bundle stable while ctrl_valid && !ctrl_ready; clear ctrl_valid after handoff when no new bundle loads on the same edge.
REQ-029 SHALL, with flush=1, clear ctrl_valid, discard any latched first word, return to WORD1, and ignore instr_valid on that edge.

Reset
REQ-030 SHALL, while rst_n=0, force state WORD1, ctrl_valid=0, instr_ready=0, every bundle output 0, latched first-word fields 0.
REQ-031 SHALL, when reset is asserted mid two-word sequence, discard the pending word; first word after release is decoded as an opcode.

Configuration
REQ-032 SHALL, with DECODER_TWO_WORD_EN defined, support LDS/STS per REQ-023..025; without it, LDS/STS encodings give illegal=1 per REQ-026, WORD2 unreachable, mem_* held 0.

Verification
REQ-033 SHALL cover: 0xE5A3 accepted, ctrl_ready=1 -> next cycle gpr_write_addr=26, data_out=0x53, data_out_en=1, gpr_write_en=1.
REQ-034 SHALL cover: 0x2C12 -> gpr_write_addr=1, gpr_read_addr=2, gpr_read_en=1, gpr_write_en=1, data_out_en=0.
REQ-035 SHALL cover: 0x9110 then 0x0460 -> no bundle after first word; after second: mem_addr=0x0460, gpr_write_addr=17, mem_read_en=1; 0x9250,0x0100 -> gpr_read_addr=5, mem_write_en=1.
REQ-036 SHALL cover: ctrl_ready=0 three cycles with LDI bundle valid -> instr_ready=0, bundle unchanged; ctrl_ready=1 -> next word accepted same edge.
REQ-037 SHALL cover: 0x9110 then flush=1 -> ctrl_valid=0; next 0xE5A3 decodes as LDI; 0xFFFF -> illegal=1, all enables 0.
